// File: rtl/po2_pkg.sv
// Shared types and packing helpers for the po2 dot-product path and its layer scheduler.
package po2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } sched_state_t;

  localparam int W_DEFAULT = 16;
  localparam int RW        = 2 * W_DEFAULT;

  // LSB offset of slot idx in a packed vector of count slots, slot 0 in the MSBs.
  function automatic int slot_lsb(input int idx, input int width, input int count);
    return width * (count - idx - 1);
  endfunction

endpackage

// File: rtl/po2_result_buffer.sv
// K-entry result store: one indexed write port, all slots presented packed MSB-first.
module po2_result_buffer
  import po2_pkg::*;
#(
  parameter int K  = 4,
  parameter int DW = RW,
  parameter int CW = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_idx,
  input  logic [DW-1:0]   wr_data,
  output logic [K*DW-1:0] rd_data
);

  logic [DW-1:0] slot_r [K];

  // Slot registers; the index guard keeps a non-power-of-two K from writing past the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        slot_r[k] <= '0;
      end
    end else if (wr_en && (int'(wr_idx) < K)) begin
      slot_r[wr_idx] <= wr_data;
    end
  end

  // Packed read-out, channel 0 in the MSBs.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < K; k++) begin
      rd_data[slot_lsb(k, DW, K) +: DW] = slot_r[k];
    end
  end

endmodule

// File: rtl/po2_layer_scheduler.sv
// Time-multiplexes one po2 dot-product engine over K output channels of a layer.
module po2_layer_scheduler
  import po2_pkg::*;
#(
  parameter int W  = 16,
  parameter int D  = 4,
  parameter int K  = 4,
  parameter int CW = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D*W-1:0]     in_data,
  input  logic               in_v,
  output logic               in_ready,
  output logic [D*W-1:0]     eng_a,
  output logic [CW-1:0]      eng_sel,
  output logic               eng_start,
  input  logic               eng_done,
  input  logic [2*W-1:0]     eng_result,
  output logic [K*2*W-1:0]   out_data,
  output logic               out_v,
  input  logic               out_ready,
  output logic               busy
);

  localparam logic [CW-1:0] CH_LAST = CW'(K - 1);

  sched_state_t  state_r, state_s;
  logic [CW-1:0] ch_r, ch_s;
  logic [D*W-1:0] eng_a_r;
  logic          load_s, wr_en_s;
  logic          in_ready_r, eng_start_r, out_v_r, busy_r;
  logic [CW-1:0] eng_sel_r;

  // Next-state logic; eng_done only counts in WAIT, so stale or stray pulses never write.
  always_comb begin
    state_s = state_r;
    ch_s    = ch_r;
    load_s  = 1'b0;
    wr_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_v && in_ready_r) begin
          state_s = ISSUE;
          ch_s    = '0;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          wr_en_s = 1'b1;
          if (ch_r == CH_LAST) begin
            state_s = EMIT;
          end else begin
            state_s = ISSUE;
            ch_s    = ch_r + 1'b1;
          end
        end else begin
          state_s = WAIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_s = IDLE;
          ch_s    = '0;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
        ch_s    = '0;
      end
    endcase
  end

  // State, counter and input latch; outputs are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ch_r        <= '0;
      eng_a_r     <= '0;
      in_ready_r  <= 1'b0;
      eng_start_r <= 1'b0;
      eng_sel_r   <= '0;
      out_v_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ch_r        <= ch_s;
      if (load_s) begin
        eng_a_r <= in_data;
      end
      in_ready_r  <= (state_s == IDLE);
      eng_start_r <= (state_s == ISSUE);
      eng_sel_r   <= ch_s;
      out_v_r     <= (state_s == EMIT);
      busy_r      <= (state_s != IDLE);
    end
  end

  po2_result_buffer #(
    .K  (K),
    .DW (2 * W),
    .CW (CW)
  ) u_result_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_idx  (ch_r),
    .wr_data (eng_result),
    .rd_data (out_data)
  );

  assign in_ready  = in_ready_r;
  assign eng_a     = eng_a_r;
  assign eng_sel   = eng_sel_r;
  assign eng_start = eng_start_r;
  assign out_v     = out_v_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_po2_layer_scheduler.sv
// Directed bench for po2_layer_scheduler with a fixed-latency mock engine (L=3).
module tb_po2_layer_scheduler;

  localparam int W = 16;
  localparam int D = 4;
  localparam int K = 4;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [D*W-1:0] in_data;
  logic           in_v;
  logic           in_ready;
  logic [D*W-1:0] eng_a;
  logic [1:0]     eng_sel;
  logic           eng_start;
  logic           eng_done;
  logic [2*W-1:0] eng_result;
  logic [K*2*W-1:0] out_data;
  logic           out_v;
  logic           out_ready;
  logic           busy;

  int checks = 0;
  int errors = 0;

  po2_layer_scheduler #(.W(W), .D(D), .K(K)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_v(in_v), .in_ready(in_ready),
    .eng_a(eng_a), .eng_sel(eng_sel), .eng_start(eng_start), .eng_done(eng_done),
    .eng_result(eng_result), .out_data(out_data), .out_v(out_v),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mock engine: done pulse L cycles after the start cycle, result = 1000*sel + signed a[0].
  logic        mock_done, inj_done, pend;
  logic [1:0]  cnt;
  logic [31:0] mock_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mock_done <= 1'b0;
      pend      <= 1'b0;
      cnt       <= 2'd0;
      mock_res  <= 32'd0;
    end else begin
      mock_done <= 1'b0;
      if (eng_start) begin
        pend     <= 1'b1;
        cnt      <= 2'(L - 1);
        mock_res <= 32'(int'(eng_sel) * 1000 + int'($signed(eng_a[63:48])));
      end else if (pend) begin
        if (cnt == 2'd1) begin
          mock_done <= 1'b1;
          pend      <= 1'b0;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end
  assign eng_done   = mock_done | inj_done;
  assign eng_result = mock_res;

  int         start_cnt = 0;
  logic [1:0] sel_log[$];
  always @(posedge clk) begin
    if (!rst && eng_start) begin
      start_cnt <= start_cnt + 1;
      sel_log.push_back(eng_sel);
    end
  end

  localparam logic [63:0]  VEC_A = {16'h0005, 16'hFFFE, 16'h0007, 16'h0001};
  localparam logic [63:0]  VEC_B = {16'hFFFD, 16'h0004, 16'h0000, 16'h0009};
  localparam logic [127:0] EXP_A = {32'd5, 32'd1005, 32'd2005, 32'd3005};
  localparam logic [127:0] EXP_B = {32'hFFFFFFFD, 32'd997, 32'd1997, 32'd2997};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers vec, returns the cycle (1 = cycle after accept) in which out_v is first seen.
  task automatic run_txn(input logic [63:0] vec, input logic inject_issue,
                         output int lat, output logic rdy_seen);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk("in_ready_before_txn", 128'(in_ready), 128'(1'b1));
    in_data = vec;
    in_v    = 1'b1;
    tick();
    in_v     = 1'b0;
    inj_done = inject_issue;
    lat      = 1;
    rdy_seen = in_ready;
    while (!out_v && lat < 100) begin
      tick();
      inj_done = 1'b0;
      lat++;
      rdy_seen = rdy_seen | in_ready;
    end
  endtask

  int         lat, base;
  logic       rdy_seen, stable;
  logic [7:0] sels;

  initial begin
    rst = 1'b1; in_v = 1'b0; in_data = '0; out_ready = 1'b0; inj_done = 1'b0;
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
    chk("rst_out_v", 128'(out_v), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_eng_start", 128'(eng_start), 128'(1'b0));
    chk("rst_eng_sel", 128'(eng_sel), 128'(2'd0));
    chk("rst_eng_a", 128'(eng_a), 128'(64'd0));
    chk("rst_out_data", out_data, 128'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_in_ready", 128'(in_ready), 128'(1'b1));
    chk("idle_busy", 128'(busy), 128'(1'b0));
    chk("idle_out_v", 128'(out_v), 128'(1'b0));
    chk("idle_no_start", 128'(start_cnt), 128'(0));

    // Single vector with out_ready high
    out_ready = 1'b1;
    sel_log.delete();
    run_txn(VEC_A, 1'b0, lat, rdy_seen);
    chk("s2_latency", 128'(lat), 128'(17));
    chk("s2_out_data", out_data, EXP_A);
    chk("s2_eng_a", 128'(eng_a), 128'(VEC_A));
    chk("s2_in_ready_low", 128'(rdy_seen), 128'(1'b0));
    chk("s2_start_count", 128'(sel_log.size()), 128'(4));
    sels = {sel_log[0], sel_log[1], sel_log[2], sel_log[3]};
    chk("s2_sel_order", 128'(sels), 128'(8'b00_01_10_11));
    tick();
    chk("s2_out_v_drop", 128'(out_v), 128'(1'b0));
    chk("s2_back_idle", 128'({in_ready, busy}), 128'(2'b10));
    chk("s2_out_data_kept", out_data, EXP_A);

    // Negative activation, sign preserved
    run_txn(VEC_B, 1'b0, lat, rdy_seen);
    chk("s3_out_data", out_data, EXP_B);
    chk("s3_slot0", 128'(out_data[127:96]), 128'(32'hFFFFFFFD));
    chk("s3_in_ready_low", 128'(rdy_seen), 128'(1'b0));
    tick();

    // Backpressure in EMIT with a competing input offer
    out_ready = 1'b0;
    run_txn(VEC_A, 1'b0, lat, rdy_seen);
    base    = start_cnt;
    in_data = VEC_B;
    in_v    = 1'b1;
    stable  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_v || out_data !== EXP_A || in_ready || eng_a !== VEC_A) stable = 1'b0;
    end
    chk("s4_emit_stable", 128'(stable), 128'(1'b1));
    chk("s4_no_new_start", 128'(start_cnt - base), 128'(0));
    out_ready = 1'b1;
    tick();
    in_v = 1'b0;
    chk("s4_idle_after_ready", 128'({out_v, in_ready, busy}), 128'(3'b010));

    // Spurious done in IDLE, then in ISSUE
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    chk("s5_idle_done_ignored", out_data, EXP_A);
    sel_log.delete();
    run_txn(VEC_A, 1'b1, lat, rdy_seen);
    chk("s5_latency", 128'(lat), 128'(17));
    chk("s5_out_data", out_data, EXP_A);
    chk("s5_start_count", 128'(sel_log.size()), 128'(4));
    tick();

    // Reset while waiting on channel 2
    in_data = VEC_B;
    in_v    = 1'b1;
    tick();
    in_v = 1'b0;
    base = start_cnt;
    for (int i = 0; i < 50 && (start_cnt - base) < 3; i++) tick();
    chk("s6_reached_ch2", 128'(start_cnt - base), 128'(3));
    tick();
    chk("s6_in_wait_sel", 128'({eng_sel, busy, eng_start}), 128'(4'b10_1_0));
    rst = 1'b1;
    #1;
    chk("s6_rst_out_v", 128'(out_v), 128'(1'b0));
    chk("s6_rst_busy", 128'(busy), 128'(1'b0));
    chk("s6_rst_out_data", out_data, 128'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("s6_idle_quiet", 128'({busy, out_v}), 128'(2'b00));
    sel_log.delete();
    run_txn(VEC_A, 1'b0, lat, rdy_seen);
    chk("s6_latency", 128'(lat), 128'(17));
    chk("s6_out_data", out_data, EXP_A);
    sels = {sel_log[0], sel_log[1], sel_log[2], sel_log[3]};
    chk("s6_sel_order", 128'(sels), 128'(8'b00_01_10_11));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/po2_layer_scheduler.md
Name: po2_layer_scheduler

Overview:
Sequences a single shared po2 dot-product engine across K output channels (filters) of one layer. Accepts one packed D-element activation vector per transaction. Issues one engine job per channel, selecting that channel's weight bank, and collects each 2W-bit result into an output buffer. Presents the full K-channel result vector downstream with a valid/ready handshake. Sits between the activation source (previous layer / input cache) and the next layer.

Parameters:
W, 16, element width of activations; engine results are 2*W.
D, 4, elements per activation vector (engine dot-product length).
K, 4, number of output channels / weight banks; must be >= 1.
CW, $clog2(K) (min 1), width of channel select.

Ports:
clk  in  1  clock.
rst  in  1  reset: asynchronous, active-high.
in_data  in  D*W  packed activations; element j at bits [W*(D-j-1) +: W] (element 0 in MSBs).
in_v  in  1  in_data valid.
in_ready  out  1  scheduler can accept a vector.
eng_a  out  D*W  latched activation vector to engine; stable for the whole transaction.
eng_sel  out  CW  weight bank / channel index for the current job.
eng_start  out  1  single-cycle pulse that launches one engine job.
eng_done  in  1  single-cycle pulse: eng_result is valid this cycle.
eng_result  in  2*W  signed engine result.
out_data  out  K*2*W  packed results; channel k at bits [2W*(K-k-1) +: 2W].
out_v  out  1  out_data valid.
out_ready  in  1  downstream accepts out_data.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async assert, all outputs): in_ready=0 while rst is high, then 1 in IDLE; eng_start=0; eng_sel=0; eng_a=0; out_v=0; out_data=0; busy=0; state=IDLE; channel counter ch=0.
- States: IDLE, ISSUE, WAIT, EMIT.
- IDLE:
  - in_ready=1.
  - On in_v&&in_ready: latch in_data into eng_a, set ch=0, go to ISSUE.
- ISSUE:
  - eng_start=1 for exactly this cycle; eng_sel=ch.
  - Next state is WAIT.
  - eng_done seen in ISSUE is stale and is ignored.
- WAIT:
  - eng_start=0; eng_sel holds ch.
  - On eng_done: write eng_result into buffer slot ch.
  - If ch==K-1, go to EMIT; else ch<=ch+1 and go to ISSUE.
  - No timeout; waits indefinitely.
- EMIT:
  - out_v=1; out_data is stable and holds all K results.
  - On out_ready, go to IDLE, drop out_v, reset ch=0.
  - out_data retains its last value after the handshake; it is not cleared.
- in_ready=0 in ISSUE, WAIT and EMIT. At most one vector is in flight; no overlap between transactions.
- Handshakes: a transfer occurs only when valid&&ready are high on the same rising edge. Sources must hold data while valid is high and ready is low.
- Latency, for engine latency L (cycles from eng_start to eng_done):
  - In a transaction accepted at edge t0, the first eng_start is high in the cycle after t0.
  - out_v rises K*(L+1)+1 cycles after the accept edge.
  - Back-to-back throughput: one vector per K*(L+1)+2 cycles when out_ready is held high.
- K=1: a single ISSUE/WAIT pass, then EMIT.
- Arithmetic: the scheduler does no arithmetic on results; they are stored verbatim at full 2W width.
- Reset mid-operation: abort immediately and return to IDLE with reset values. The engine must be reset from the same rst. Any later eng_done is ignored because the scheduler is in IDLE.
- eng_done while in IDLE or EMIT: ignored, no buffer write.

Decomposition:
- Shared package po2_pkg:
  - state enum sched_state_t {IDLE, ISSUE, WAIT, EMIT}.
  - Result width constant RW = 2*W.
  - Functions for packed-slot offset (MSB-first) used by this block and the dot-product path.
- Sub-module po2_result_buffer (K x 2W registers with write-enable and index, packed read-out) is the natural split. The FSM, channel counter and input latch stay in po2_layer_scheduler.

Test Plan:
Bench uses a mock engine: asserts eng_done L=3 cycles after eng_start, with result = 1000*eng_sel + signed a[0].
1. Reset then idle: rst pulse -> in_ready=1, out_v=0, eng_start never asserted, busy=0.
2. Single vector a=[5,-2,7,1], K=4, out_ready=1 -> eng_start pulses with eng_sel 0,1,2,3; out_data slots = [5, 1005, 2005, 3005]; out_v rises exactly 17 cycles after accept.
3. Negative result: a[0]=-3 -> slot 0 = 32'hFFFFFFFD (sign preserved); in_ready=0 throughout the transaction.
4. Backpressure: out_ready held 0 for 10 cycles in EMIT -> out_v and out_data stable; a new in_v is not accepted; on out_ready=1 -> IDLE next cycle.
5. Spurious done: eng_done injected in ISSUE and in IDLE -> no buffer change, results identical to scenario 2.
6. Reset mid-WAIT (ch=2) -> out_v=0, busy=0 immediately; a following clean transaction yields the correct scenario 2 values.
